key_debounce: RTL and testbench



---
 rtl/key_pkg.sv | 24 ++
 rtl/key_debounce_if.sv | 27 ++
 rtl/key_debounce_ch.sv | 135 +++++++++++++
 rtl/key_debounce.sv | 30 +++
 tb/tb_key_debounce.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the push-button debounce block:
// per-channel FSM state encoding and a constant ceil-log2 helper.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key bundle between the raw DE10 push-buttons and their consumers.
// The master drives the raw active-low pins; the slave (debouncer) returns clean events.
interface key_debounce_if #(
    parameter int N_KEYS = 2
);
    logic [N_KEYS-1:0] KEY_N;
    logic [N_KEYS-1:0] KEY_LVL;
    logic [N_KEYS-1:0] KEY_PRESS;
    logic [N_KEYS-1:0] KEY_RELEASE;
    logic [N_KEYS-1:0] KEY_LONG;

    modport master (
        output KEY_N,
        input  KEY_LVL,
        input  KEY_PRESS,
        input  KEY_RELEASE,
        input  KEY_LONG
    );

    modport slave (
        input  KEY_N,
        output KEY_LVL,
        output KEY_PRESS,
        output KEY_RELEASE,
        output KEY_LONG
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-flop synchroniser, debounce FSM with a stability
// counter, hold counter for long-press detection, and registered event outputs.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_lvl,
    output logic o_press,
    output logic o_release,
    output logic o_long
);
    localparam int DW = clog2(DEBOUNCE_CYCLES);
    localparam int HW = clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HCNT_ONE  = HW'(1);

    logic          r_sync1, r_sync2;
    key_state_t    r_state, w_state;
    logic [DW-1:0] r_dcnt, w_dcnt;
    logic [HW-1:0] r_hcnt, w_hcnt;
    logic          r_lvl, w_lvl;
    logic          r_press, w_press;
    logic          r_release, w_release;
    logic          r_long, w_long;
    logic          w_s;

    // Synchroniser idles at 1 so a reset looks like a released key.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_dcnt    <= '0;
            r_hcnt    <= '0;
            r_lvl     <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_dcnt    <= w_dcnt;
            r_hcnt    <= w_hcnt;
            r_lvl     <= w_lvl;
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
        end
    end

    // hcnt keeps counting on the edge HELD leaves for RELEASE_WAIT and is frozen
    // for every RELEASE_WAIT edge, so a release bounce of n cycles delays KEY_LONG by n.
    always_comb begin
        w_state   = r_state;
        w_dcnt    = r_dcnt;
        w_hcnt    = r_hcnt;
        w_lvl     = r_lvl;
        w_press   = 1'b0;
        w_release = 1'b0;
        w_long    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_lvl  = 1'b0;
                w_hcnt = '0;
                if (!w_s) begin
                    w_state = PRESS_WAIT;
                    w_dcnt  = DCNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (w_s) begin
                    w_state = IDLE;
                    w_dcnt  = '0;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state = HELD;
                    w_dcnt  = '0;
                    w_hcnt  = '0;
                    w_lvl   = 1'b1;
                    w_press = 1'b1;
                end else begin
                    w_dcnt = r_dcnt + DCNT_ONE;
                end
            end
            HELD: begin
                if (r_hcnt != HCNT_MAX) begin
                    w_hcnt = r_hcnt + HCNT_ONE;
                    w_long = (r_hcnt == HCNT_MAX - HCNT_ONE);
                end
                if (w_s) begin
                    w_state = RELEASE_WAIT;
                    w_dcnt  = DCNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (!w_s) begin
                    w_state = HELD;
                    w_dcnt  = '0;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state   = IDLE;
                    w_dcnt    = '0;
                    w_hcnt    = '0;
                    w_lvl     = 1'b0;
                    w_release = 1'b1;
                end else begin
                    w_dcnt = r_dcnt + DCNT_ONE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign o_lvl     = r_lvl;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/key_debounce.sv
// Debounce and event detection for the DE10 push-buttons; one independent
// key_debounce_ch per key, all in the single CLK domain.
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000
) (
    input  logic           CLK,
    input  logic           RST_N,
    key_debounce_if.slave  keys
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .i_clk     (CLK),
            .i_rst_n   (RST_N),
            .i_key_n   (keys.KEY_N[g]),
            .o_lvl     (keys.KEY_LVL[g]),
            .o_press   (keys.KEY_PRESS[g]),
            .o_release (keys.KEY_RELEASE[g]),
            .o_long    (keys.KEY_LONG[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: directed key waveforms queue the expected
// pulse events by edge number; a negedge monitor matches every pulse the DUT emits.
module tb_key_debounce;

    localparam int D = 8;
    localparam int L = 32;
    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } evt_t;

    logic CLK = 1'b0;
    logic RST_N;
    int   edgeCnt = 0;
    int   checks  = 0;
    int   errors  = 0;
    evt_t expQ[$];

    key_debounce_if #(.N_KEYS(2)) keys ();

    key_debounce #(
        .N_KEYS          (2),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .keys  (keys)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edgeCnt <= edgeCnt + 1;

    function automatic string kindName(input int k);
        case (k)
            K_PRESS:   return "press";
            K_RELEASE: return "release";
            default:   return "long";
        endcase
    endfunction

    function automatic logic pulseOf(input int k, input int ch);
        case (k)
            K_PRESS:   return keys.KEY_PRESS[ch];
            K_RELEASE: return keys.KEY_RELEASE[ch];
            default:   return keys.KEY_LONG[ch];
        endcase
    endfunction

    // Every pulse must match a queued event of the same kind and channel at the queued edge.
    always @(negedge CLK) begin
        for (int ch = 0; ch < 2; ch++) begin
            for (int k = 0; k < 3; k++) begin
                if (pulseOf(k, ch)) begin
                    int idx;
                    idx = -1;
                    checks++;
                    for (int i = 0; i < expQ.size(); i++) begin
                        if (idx < 0 && expQ[i].kind == k && expQ[i].ch == ch) idx = i;
                    end
                    if (idx < 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_%s ch%0d: pulse at edge %0d, required none",
                                 kindName(k), ch, edgeCnt);
                    end else begin
                        if (expQ[idx].cyc != edgeCnt) begin
                            errors++;
                            $display("[TB] FAIL timing_%s ch%0d: pulse at edge %0d, required edge %0d",
                                     kindName(k), ch, edgeCnt, expQ[idx].cyc);
                        end
                        expQ.delete(idx);
                    end
                end
            end
        end
    end

    task automatic stepTo(input int e);
        while (edgeCnt < e) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input int e, input logic [1:0] keyN);
        stepTo(e);
        keys.KEY_N = keyN;
    endtask

    task automatic expectEvt(input int kind, input int ch, input int cyc);
        evt_t ev;
        ev.cyc  = cyc;
        ev.kind = kind;
        ev.ch   = ch;
        expQ.push_back(ev);
    endtask

    task automatic checkOutput(input string name, input logic [1:0] expLvl);
        checks++;
        if (keys.KEY_LVL !== expLvl) begin
            errors++;
            $display("[TB] FAIL %s: KEY_LVL got %b required %b at edge %0d",
                     name, keys.KEY_LVL, expLvl, edgeCnt);
        end
    endtask

    task automatic checkIdle(input string name);
        checks++;
        if ({keys.KEY_PRESS, keys.KEY_RELEASE, keys.KEY_LONG} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL %s: pulses got %b required 000000 at edge %0d",
                     name, {keys.KEY_PRESS, keys.KEY_RELEASE, keys.KEY_LONG}, edgeCnt);
        end
    endtask

    initial begin
        RST_N      = 1'b0;
        keys.KEY_N = 2'b00;

        // Both keys held through reset: fresh presses 10 edges after release.
        stepTo(3);
        checkOutput("reset_lvl", 2'b00);
        checkIdle("reset_pulses");
        stepTo(5);
        RST_N = 1'b1;
        expectEvt(K_PRESS, 0, 15);
        expectEvt(K_PRESS, 1, 15);
        stepTo(14);
        checkOutput("rst_rel_lvl_before", 2'b00);
        stepTo(15);
        checkOutput("rst_rel_lvl_after", 2'b11);
        applyStimulus(20, 2'b11);
        expectEvt(K_RELEASE, 0, 30);
        expectEvt(K_RELEASE, 1, 30);
        stepTo(29);
        checkOutput("rel_both_before", 2'b11);
        stepTo(30);
        checkOutput("rel_both_after", 2'b00);

        // Clean press on key 0.
        applyStimulus(100, 2'b10);
        expectEvt(K_PRESS, 0, 110);
        stepTo(109);
        checkOutput("clean_before", 2'b00);
        stepTo(110);
        checkOutput("clean_after", 2'b01);
        applyStimulus(120, 2'b11);
        expectEvt(K_RELEASE, 0, 130);
        stepTo(130);
        checkOutput("clean_released", 2'b00);

        // Press bounce: low 5, high 3, low 6.
        applyStimulus(150, 2'b10);
        applyStimulus(155, 2'b11);
        applyStimulus(158, 2'b10);
        applyStimulus(164, 2'b11);
        stepTo(180);
        checkOutput("bounce_lvl", 2'b00);

        // Boundary: 7 low cycles rejected, 8 low cycles accepted.
        applyStimulus(200, 2'b01);
        applyStimulus(207, 2'b11);
        stepTo(220);
        checkOutput("glitch7_lvl", 2'b00);
        applyStimulus(230, 2'b01);
        expectEvt(K_PRESS, 1, 240);
        applyStimulus(238, 2'b11);
        expectEvt(K_RELEASE, 1, 248);
        stepTo(240);
        checkOutput("min8_pressed", 2'b10);
        stepTo(247);
        checkOutput("min8_still", 2'b10);
        stepTo(248);
        checkOutput("min8_released", 2'b00);

        // Long press on key 1: 60 cycles low.
        applyStimulus(300, 2'b01);
        expectEvt(K_PRESS, 1, 310);
        expectEvt(K_LONG, 1, 342);
        stepTo(341);
        checkOutput("long_held", 2'b10);
        applyStimulus(360, 2'b11);
        expectEvt(K_RELEASE, 1, 370);
        stepTo(369);
        checkOutput("long_before_rel", 2'b10);
        stepTo(370);
        checkOutput("long_released", 2'b00);

        // Release bounce on key 0: 4 cycles high while held delays the long pulse by 4.
        applyStimulus(400, 2'b10);
        expectEvt(K_PRESS, 0, 410);
        expectEvt(K_LONG, 0, 446);
        applyStimulus(420, 2'b11);
        applyStimulus(424, 2'b10);
        stepTo(426);
        checkOutput("relbounce_lvl", 2'b01);
        applyStimulus(460, 2'b11);
        expectEvt(K_RELEASE, 0, 470);
        stepTo(470);
        checkOutput("relbounce_released", 2'b00);

        // Reset while key 1 is held and key 0 is in PRESS_WAIT with dcnt=5.
        applyStimulus(480, 2'b01);
        expectEvt(K_PRESS, 1, 490);
        applyStimulus(500, 2'b00);
        stepTo(507);
        RST_N = 1'b0;
        #1;
        checkOutput("midrst_lvl", 2'b00);
        checkIdle("midrst_pulses");
        stepTo(512);
        RST_N = 1'b1;
        expectEvt(K_PRESS, 0, 522);
        expectEvt(K_PRESS, 1, 522);
        stepTo(521);
        checkOutput("midrst_before", 2'b00);
        stepTo(522);
        checkOutput("midrst_after", 2'b11);
        applyStimulus(530, 2'b11);
        expectEvt(K_RELEASE, 0, 540);
        expectEvt(K_RELEASE, 1, 540);
        stepTo(540);
        checkOutput("midrst_released", 2'b00);

        stepTo(560);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            foreach (expQ[i])
                $display("[TB] FAIL missing_%s ch%0d: no pulse seen, required at edge %0d",
                         kindName(expQ[i].kind), expQ[i].ch, expQ[i].cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
